// File: rtl/red_seq_unit.sv
// rtl/red_seq_unit.sv - multi-cycle nibble-reduction (RED) unit with valid/ready operand and result handshakes
// Optional build macro RED_SAT_EN: saturate the result at 63 instead of wrapping modulo 64.
module red_seq_unit #(
    parameter int PAIRS_PER_CYC = 1,
    parameter int W             = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         In_valid,
    output logic         In_ready,
    input  logic [W-1:0] In1,
    input  logic [W-1:0] In2,
    output logic         Out_valid,
    input  logic         Out_ready,
    output logic [W-1:0] Out,
    output logic         Busy
);

    generate
        if (!(PAIRS_PER_CYC == 1 || PAIRS_PER_CYC == 2 || PAIRS_PER_CYC == 4)) begin : g_bad_pairs
            $error("red_seq_unit: PAIRS_PER_CYC must be 1, 2 or 4");
        end
        if (W != 16) begin : g_bad_width
            $error("red_seq_unit: W must be 16");
        end
    endgenerate

    localparam int          NPAIRS = W / 4;
    localparam int          STEPS  = NPAIRS / PAIRS_PER_CYC;
    localparam logic [2:0]  LAST   = 3'(STEPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [6:0]   acc;
    logic [2:0]   idx;
    logic [W-1:0] out_reg;
    logic [6:0]   step_sum;
    logic [5:0]   res6;

    // Nibble pairs for this step, lowest nibble position first; the
    // finalize step (idx == LAST) indexes past the operand and adds nothing.
    always_comb begin
        step_sum = 7'd0;
        for (int j = 0; j < PAIRS_PER_CYC; j++) begin
            int k;
            k = int'(idx) * PAIRS_PER_CYC + j;
            if (k < NPAIRS) begin
                step_sum = step_sum + {3'b000, a_reg[k*4 +: 4]} + {3'b000, b_reg[k*4 +: 4]};
            end
        end
    end

    always_comb begin
`ifdef RED_SAT_EN
        res6 = (acc > 7'd63) ? 6'h3F : acc[5:0];
`else
        res6 = acc[5:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= 7'd0;
            idx     <= 3'd0;
            out_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (In_valid) begin
                        a_reg <= In1;
                        b_reg <= In2;
                        acc   <= 7'd0;
                        idx   <= 3'd0;
                        state <= S_ACC;
                    end
                end
                S_ACC: begin
                    // One extra step after the last add registers the result,
                    // so Out is never driven from the adder tree.
                    if (idx == LAST) begin
                        out_reg <= {{(W-6){1'b0}}, res6};
                        state   <= S_DONE;
                    end else begin
                        acc <= acc + step_sum;
                        idx <= idx + 3'd1;
                    end
                end
                S_DONE: begin
                    if (Out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign In_ready  = (state == S_IDLE);
    assign Out_valid = (state == S_DONE);
    assign Busy      = (state == S_ACC) || (state == S_DONE);
    assign Out       = out_reg;

endmodule
